// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the alu_seq command sequencer.
// Build option: ALU_SEQ_CARRY_CHAIN_EN feeds the stored carry into the ALU.
package alu_seq_pkg;

    localparam int REG_COUNT = 16;
    localparam int DATA_W    = 16;
    localparam int FLAG_W    = 5;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;
    localparam int FLAG_P = 4;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_MOVB = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_e;

    typedef struct packed {
        logic [3:0]        op;
        logic [3:0]        rdest;
        logic              wb_en;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

    function automatic logic parity16(input logic [DATA_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 16-bit ALU: add/sub with carry-in, logic ops, shifts.
// Flags: {P, V, N, Z, C}; logic and shift ops clear C and V.
module alu
    import alu_seq_pkg::*;
(
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              c_in,
    output logic [DATA_W-1:0] result,
    output logic [FLAG_W-1:0] flags
);

    logic [DATA_W:0] wide;
    logic            c;
    logic            v;

    always_comb begin
        wide   = '0;
        c      = 1'b0;
        v      = 1'b0;
        result = '0;
        case (opcode)
            OP_ADD: begin
                wide   = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, c_in};
                result = wide[DATA_W-1:0];
                c      = wide[DATA_W];
                v      = (a[15] == b[15]) && (result[15] != a[15]);
            end
            OP_SUB: begin
                // C is the borrow out
                wide   = {1'b0, a} - {1'b0, b} - {{DATA_W{1'b0}}, c_in};
                result = wide[DATA_W-1:0];
                c      = wide[DATA_W];
                v      = (a[15] != b[15]) && (result[15] != a[15]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_MOVB: result = b;
            OP_SHL:  result = a << b;
            OP_SHR:  result = a >> b;
            default: result = '0;
        endcase
        flags = {parity16(result), v, result[15], (result == '0), c};
    end

endmodule

// File: rtl/alu_seq.sv
// Three-state command sequencer around the ALU with an inline 16x16 register file.
// Build option: ALU_SEQ_CARRY_CHAIN_EN drives alu.c_in from flags[0].
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int               IMM_W       = 8,
    parameter logic [FLAG_W-1:0] RESET_FLAGS = 5'b00000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [3:0]        cmd_rdest,
    input  logic [3:0]        cmd_rsrc,
    input  logic              cmd_imm_en,
    input  logic [IMM_W-1:0]  cmd_imm,
    input  logic              cmd_wb_en,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [FLAG_W-1:0] flags,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_e            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [FLAG_W-1:0] aflags_q, aflags_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic [DATA_W-1:0] regs_q [REG_COUNT];
    logic              wr_en;

    logic [DATA_W-1:0] rf_a, rf_b, imm_ext, opb;
    logic [DATA_W-1:0] alu_res;
    logic [FLAG_W-1:0] alu_flags;
    logic              c_in;

    assign rf_a     = regs_q[cmd_rdest];
    assign rf_b     = regs_q[cmd_rsrc];
    assign dbg_data = regs_q[dbg_addr];
    assign imm_ext  = {{(DATA_W-IMM_W){cmd_imm[IMM_W-1]}}, cmd_imm};
    assign opb      = cmd_imm_en ? imm_ext : rf_b;

`ifdef ALU_SEQ_CARRY_CHAIN_EN
    assign c_in = flags_q[FLAG_C];
`else
    assign c_in = 1'b0;
`endif

    alu u_alu (
        .opcode (cmd_q.op),
        .a      (cmd_q.a),
        .b      (cmd_q.b),
        .c_in   (c_in),
        .result (alu_res),
        .flags  (alu_flags)
    );

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        result_d  = result_q;
        aflags_d  = aflags_q;
        flags_d   = flags_q;
        wr_en     = 1'b0;
        done      = 1'b0;
        cmd_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cmd_d.op    = cmd_op;
                    cmd_d.rdest = cmd_rdest;
                    cmd_d.wb_en = cmd_wb_en;
                    cmd_d.a     = rf_a;
                    cmd_d.b     = opb;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_res;
                aflags_d = alu_flags;
                state_d  = WB;
            end
            WB: begin
                done    = 1'b1;
                flags_d = aflags_q;
                wr_en   = cmd_q.wb_en;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            result_q <= '0;
            aflags_q <= '0;
            flags_q  <= RESET_FLAGS;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            result_q <= result_d;
            aflags_q <= aflags_d;
            flags_q  <= flags_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[cmd_q.rdest] <= result_q;
        end
    end

    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: hand-computed results, flags, latency and reset abort.
// Define ALU_SEQ_CARRY_CHAIN_EN for the bench too when the RTL is built with it.
module tb_alu_seq;

    localparam logic [3:0] ADD  = 4'h0;
    localparam logic [3:0] SUB  = 4'h1;
    localparam logic [3:0] OR_  = 4'h3;
    localparam logic [3:0] MOVB = 4'h5;
    localparam logic [3:0] SHL  = 4'h6;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [3:0]  cmd_op, cmd_rdest, cmd_rsrc;
    logic        cmd_imm_en, cmd_wb_en;
    logic [7:0]  cmd_imm;
    logic        done;
    logic [15:0] result;
    logic [4:0]  flags;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    int n_vec = 0;
    int n_bad = 0;

    alu_seq dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_rdest  (cmd_rdest),
        .cmd_rsrc   (cmd_rsrc),
        .cmd_imm_en (cmd_imm_en),
        .cmd_imm    (cmd_imm),
        .cmd_wb_en  (cmd_wb_en),
        .done       (done),
        .result     (result),
        .flags      (flags),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic rd_reg(input logic [3:0] a, input logic [15:0] exp,
                          input string tag);
        dbg_addr = a;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    task automatic drive(input logic [3:0] op, input logic [3:0] rd,
                         input logic [3:0] rs, input logic ie,
                         input logic [7:0] imm, input logic wb);
        cmd_op     = op;
        cmd_rdest  = rd;
        cmd_rsrc   = rs;
        cmd_imm_en = ie;
        cmd_imm    = imm;
        cmd_wb_en  = wb;
    endtask

    task automatic scramble();
        cmd_op    = 4'hE;
        cmd_rdest = 4'hF;
        cmd_rsrc  = 4'hF;
        cmd_imm   = 8'h7E;
        cmd_wb_en = 1'b1;
    endtask

    // One command: handshake, then latency, single done pulse.
    task automatic run(input logic [3:0] op, input logic [3:0] rd,
                       input logic [3:0] rs, input logic ie,
                       input logic [7:0] imm, input logic wb,
                       input string tag);
        int lat;
        @(negedge clk);
        chk({tag, " ready"}, cmd_ready, 1);
        drive(op, rd, rs, ie, imm, wb);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        scramble();
        lat = 0;
        while (lat < 5) begin
            @(negedge clk);
            lat++;
            if (done) break;
        end
        chk({tag, " latency"}, lat, 2);
        @(negedge clk);
        chk({tag, " done pulse"}, done, 0);
    endtask

    int hs, dn, rdy;

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        dbg_addr  = '0;
        drive(4'h0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst ready", cmd_ready, 1);
        chk("rst done", done, 0);
        chk("rst flags", flags, 5'h00);
        chk("rst result", result, 16'h0000);
        for (int i = 0; i < 16; i++) rd_reg(4'(i), 16'h0000, "rst reg");

        run(ADD, 4'd1, 4'd0, 1'b1, 8'h05, 1'b1, "add5");
        rd_reg(4'd1, 16'h0005, "R1=5");
        chk("add5 result", result, 16'h0005);
        chk("add5 flags", flags, 5'h00);
        run(ADD, 4'd1, 4'd0, 1'b1, 8'hFF, 1'b1, "addm1");
        rd_reg(4'd1, 16'h0004, "R1=4");
        chk("addm1 flags", flags, 5'h11);

        run(MOVB, 4'd2, 4'd0, 1'b1, 8'h12, 1'b1, "mov12");
        run(SHL,  4'd2, 4'd0, 1'b1, 8'h08, 1'b1, "shl8");
        run(OR_,  4'd2, 4'd0, 1'b1, 8'h34, 1'b1, "or34");
        rd_reg(4'd2, 16'h1234, "R2=1234");
        chk("or34 flags", flags, 5'h10);
        run(SUB, 4'd2, 4'd2, 1'b0, 8'h00, 1'b0, "cmp");
        rd_reg(4'd2, 16'h1234, "cmp R2 kept");
        chk("cmp flags", flags, 5'h02);
        chk("cmp result", result, 16'h0000);

        // valid held high across three commands
        @(negedge clk);
        drive(ADD, 4'd7, 4'd0, 1'b1, 8'h01, 1'b1);
        cmd_valid = 1'b1;
        hs = 0; dn = 0; rdy = 0;
        for (int i = 0; i < 9; i++) begin
            if (cmd_valid && cmd_ready) hs++;
            if (cmd_ready) rdy++;
            if (done) dn++;
            if (i == 8) cmd_valid = 1'b0;
            @(negedge clk);
        end
        chk("b2b handshakes", hs, 3);
        chk("b2b ready cycles", rdy, 3);
        chk("b2b dones", dn, 3);
        rd_reg(4'd7, 16'h0003, "R7=3");
        chk("b2b result", result, 16'h0003);

        run(MOVB, 4'd2, 4'd0, 1'b1, 8'h55, 1'b1, "mov55");
        run(SHL,  4'd2, 4'd0, 1'b1, 8'h08, 1'b1, "shl8b");
        run(OR_,  4'd2, 4'd0, 1'b1, 8'h55, 1'b1, "or55");
        run(SHL,  4'd2, 4'd0, 1'b1, 8'h01, 1'b1, "shl1");
        rd_reg(4'd2, 16'hAAAA, "R2=AAAA");

        // reset during EXEC of R3 <= R2
        @(negedge clk);
        drive(MOVB, 4'd3, 4'd2, 1'b0, 8'h00, 1'b1);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        #2;
        reset = 1'b1;
        @(negedge clk);
        chk("abort done a", done, 0);
        @(posedge clk);
        #1;
        chk("abort done b", done, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort ready", cmd_ready, 1);
        chk("abort done c", done, 0);
        rd_reg(4'd3, 16'h0000, "abort R3");
        @(negedge clk);
        chk("abort done d", done, 0);
        rd_reg(4'd3, 16'h0000, "abort R3 late");
        chk("abort result", result, 16'h0000);

        run(MOVB, 4'd5, 4'd0, 1'b1, 8'hFF, 1'b1, "movFF");
        rd_reg(4'd5, 16'hFFFF, "R5=FFFF");
        run(ADD, 4'd5, 4'd0, 1'b1, 8'h01, 1'b1, "carryset");
        rd_reg(4'd5, 16'h0000, "R5=0");
        chk("carryset flags", flags, 5'h03);
        run(ADD, 4'd6, 4'd0, 1'b1, 8'h00, 1'b1, "chain");
`ifdef ALU_SEQ_CARRY_CHAIN_EN
        rd_reg(4'd6, 16'h0001, "chain R6");
        chk("chain flags", flags, 5'h10);
`else
        rd_reg(4'd6, 16'h0000, "chain R6");
        chk("chain flags", flags, 5'h02);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: IMM_W, default 8, immediate field width; sign-extended to 16 bits.
REQ-002 Parameter: RESET_FLAGS, default 5'b00000, flags register value after reset.
REQ-003 Port: clk  input  1  sole clock; all state rising-edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: cmd_valid  input  1  command present.
REQ-006 Port: cmd_ready  output  1  sequencer can accept a command.
REQ-007 Port: cmd_op  input  4  ALU opcode, passed unmodified to alu.opcode.
REQ-008 Port: cmd_rdest  input  4  destination register and operand A source.
REQ-009 Port: cmd_rsrc  input  4  operand B source register.
REQ-010 Port: cmd_imm_en  input  1  1 selects sign-extended cmd_imm as operand B instead of cmd_rsrc.
REQ-011 Port: cmd_imm  input  IMM_W  immediate operand.
REQ-012 Port: cmd_wb_en  input  1  0 suppresses register writeback (compare-style ops); flags still update.
REQ-013 Port: done  output  1  one-cycle pulse on command completion.
REQ-014 Port: result  output  16  ALU result of the last completed command.
REQ-015 Port: flags  output  5  flags register, updated on completion.
REQ-016 Port: dbg_addr  input  4  debug read address.
REQ-017 Port: dbg_data  output  16  combinational read of register dbg_addr, for seven-segment display.

Function
REQ-018 Register file: 16 x 16-bit; 2 internal read ports, 1 write port, plus debug read port.
REQ-019 FSM states: IDLE, EXEC, WB; reset state IDLE.
REQ-020 cmd_ready = 1 only in IDLE; handshake when cmd_valid && cmd_ready.
REQ-021 IDLE -> EXEC on handshake: latch op, rdest, wb_en; latch operand A = R[rdest], operand B = imm-extended or R[rsrc].
REQ-022 EXEC: ALU combinationally evaluates latched operands; result and ALU flags registered at end of cycle; -> WB.
REQ-023 WB: if wb_en, R[rdest] <= result; flags <= registered ALU flags; done = 1; -> IDLE.
REQ-024 Latency: handshake edge to done asserted = 2 cycles; next handshake possible the cycle after done (throughput 1 command / 3 cycles).
REQ-025 cmd_valid while not in IDLE is ignored; no queuing; all cmd_* inputs are sampled only at handshake.
REQ-026 rdest == rsrc legal; operands use pre-writeback values.
REQ-027 dbg_data reflects a WB write from the cycle after the write edge.
REQ-028 result and flags hold their values between commands.
REQ-029 Opcode values not decoded by the sequencer; unknown opcodes complete normally with whatever the ALU produces.

Reset
REQ-030 reset asserted: state = IDLE, done = 0, result = 0, flags = RESET_FLAGS, all registers = 0, latched command cleared.
REQ-031 Reset mid-command (EXEC or WB) aborts it: no register write, no done pulse.
REQ-032 cmd_ready = 1 in the first cycle after reset deasserts.

Configuration
REQ-033 Macro ALU_SEQ_CARRY_CHAIN_EN defined: alu.c_in driven by stored carry bit flags[0], enabling multi-word add/sub chains.
REQ-034 Macro undefined: alu.c_in tied to 1'b0; flags register still updated normally.

Structure
REQ-035 Shared package alu_seq_pkg: FSM state enum (IDLE, EXEC, WB), flag bit index constants (carry = 0), REG_COUNT = 16, DATA_W = 16.
REQ-036 One sub-module: existing alu instantiated unmodified; register file inline in alu_seq.

Verification
REQ-037 After reset: dbg_data = 0 for all 16 addresses, flags = RESET_FLAGS, cmd_ready = 1, done = 0.
REQ-038 Immediate load then add: imm 8'h05 into R1 (R1 cleared, add op), then R1 += imm 8'hFF -> R1 = 16'h0004, done exactly 2 cycles after each handshake.
REQ-039 cmd_wb_en = 0 with R2 = 16'h1234: R2 unchanged on dbg_data, flags updated, done pulses once.
REQ-040 cmd_valid held high continuously for 3 back-to-back commands: exactly 3 handshakes, cmd_ready low in EXEC/WB, one done per command.
REQ-041 Reset asserted during EXEC of a write to R3 = 16'hAAAA: R3 reads 0, no done pulse, IDLE next cycle after reset deasserts.
REQ-042 With ALU_SEQ_CARRY_CHAIN_EN: 16'hFFFF + 16'h0001 sets carry, following add of 0 + 0 yields 16'h0001; without macro yields 16'h0000.
